// File: rtl/image_reader.sv
// image_reader: raster-scans a cropped frame out of the frame RAM toward the LED matrix driver.
// Optional IMAGE_READER_SERPENTINE_EN reads odd rows right-to-left.
module image_reader #(
    parameter int IN_ADDR_WIDTH      = 11,
    parameter int IMG_WIDTH_MAX_LOG2 = 6,
    parameter int DATA_WIDTH         = 24
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [IMG_WIDTH_MAX_LOG2-1:0] IMAGE_WIDTH,
    input  logic [5:0]                    IMAGE_HEIGHT,
    input  logic                          START,
    output logic                          RD_EN,
    output logic [IN_ADDR_WIDTH-1:0]      RD_ADDR,
    input  logic [DATA_WIDTH-1:0]         RD_DATA,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [DATA_WIDTH-1:0]         OUT_DATA,
    output logic [IMG_WIDTH_MAX_LOG2-1:0] OUT_X,
    output logic [5:0]                    OUT_Y,
    output logic                          OUT_LINE_END,
    output logic                          OUT_FRAME_END,
    output logic                          BUSY,
    output logic                          FRAME_DONE
);
    localparam int XW = IMG_WIDTH_MAX_LOG2;
    localparam int YW = 6;
    localparam int AW = IN_ADDR_WIDTH;
    localparam logic [XW-1:0] X_ONE = 1;
    localparam logic [YW-1:0] Y_ONE = 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          le;
        logic          fe;
    } tag_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        tag_t                  tag;
    } pix_t;

    state_t        state_q, state_d;
    logic [XW-1:0] w_q, w_d, x_q, x_d;
    logic [YW-1:0] h_q, h_d, y_q, y_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          fly_q, fly_d;
    tag_t          fly_tag_q, fly_tag_d;
    pix_t          buf_q [2];
    pix_t          buf_d [2];
    logic          head_q, head_d;
    logic [1:0]    cnt_q, cnt_d;

    logic [XW-1:0] w_m1, col;
    logic          last_col, last_row, pop, frame_done, start_ok, rd;

    always_comb begin
        w_m1       = w_q - X_ONE;
        last_col   = x_q == w_m1;
        last_row   = y_q == h_q - Y_ONE;
`ifdef IMAGE_READER_SERPENTINE_EN
        col        = y_q[0] ? w_m1 - x_q : x_q;
`else
        col        = x_q;
`endif
        pop        = (cnt_q != 2'd0) && OUT_READY;
        frame_done = (state_q == DRAIN) && (cnt_q == 2'd0) && !fly_q;
        start_ok   = START && (state_q == IDLE || frame_done) &&
                     (IMAGE_WIDTH != '0) && (IMAGE_HEIGHT != '0);
        // the entry leaving this cycle frees its slot before the new read lands
        rd         = (state_q == READ) && (({1'b0, fly_q} + cnt_q - {1'b0, pop}) < 2'd2);
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        if (frame_done)
            state_d = IDLE;
        if (start_ok) begin
            state_d    = READ;
            w_d        = IMAGE_WIDTH;
            h_d        = IMAGE_HEIGHT;
            x_d        = '0;
            y_d        = '0;
            row_base_d = '0;
        end
        if (rd) begin
            x_d        = last_col ? '0 : x_q + X_ONE;
            y_d        = last_col ? y_q + Y_ONE : y_q;
            row_base_d = last_col ? row_base_q + AW'(w_q) : row_base_q;
            if (last_col && last_row)
                state_d = DRAIN;
        end
        fly_d     = rd;
        fly_tag_d = '{x: col, y: y_q, le: last_col, fe: last_col && last_row};
        buf_d     = buf_q;
        if (fly_q)
            buf_d[head_q ^ cnt_q[0]] = '{data: RD_DATA, tag: fly_tag_q};
        head_d    = head_q ^ pop;
        cnt_d     = cnt_q + {1'b0, fly_q} - {1'b0, pop};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            fly_q      <= 1'b0;
            fly_tag_q  <= '0;
            buf_q      <= '{default: '0};
            head_q     <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            fly_q      <= fly_d;
            fly_tag_q  <= fly_tag_d;
            buf_q      <= buf_d;
            head_q     <= head_d;
            cnt_q      <= cnt_d;
        end
    end

    assign RD_EN         = rd;
    assign RD_ADDR       = rd ? row_base_q + AW'(col) : '0;
    assign OUT_VALID     = cnt_q != 2'd0;
    assign OUT_DATA      = buf_q[head_q].data;
    assign OUT_X         = buf_q[head_q].tag.x;
    assign OUT_Y         = buf_q[head_q].tag.y;
    assign OUT_LINE_END  = buf_q[head_q].tag.le;
    assign OUT_FRAME_END = buf_q[head_q].tag.fe;
    assign BUSY          = (state_q != IDLE) && !frame_done;
    assign FRAME_DONE    = frame_done;
endmodule
